// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetch stage: opcodes,
// bus/entry widths, FSM state encoding and immediate decoders.
package inst_fetcher_pkg;

    localparam int DATA_BUS_W = 32;
    localparam int ENTRY_W    = 2 * DATA_BUS_W + 1;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_BUS_W-1:0] pc;
        logic [DATA_BUS_W-1:0] inst;
        logic                  pred;
    } queue_entry_t;

    function automatic logic [DATA_BUS_W-1:0] imm_j(input logic [DATA_BUS_W-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [DATA_BUS_W-1:0] imm_b(input logic [DATA_BUS_W-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular instruction FIFO. Flush beats push/pop; all state freezes when
// i_en is low. Storage is reset so the empty head reads as zero.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_wr_en;

    assign w_push = i_en && !i_flush && i_push;
    assign w_pop  = i_en && !i_flush && i_pop && (r_count != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en[i]) begin
                    r_mem[i] <= i_push_data;
                end
            end
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding word read, JAL/branch pre-decode for the next
// fetch PC, and a queue of fetched instructions drained by decode.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clr,
    input  logic [DATA_BUS_W-1:0] clr_pc,
    output logic                  mem_req,
    output logic [DATA_BUS_W-1:0] mem_addr,
    input  logic                  mem_done,
    input  logic [DATA_BUS_W-1:0] mem_data,
    output logic [DATA_BUS_W-1:0] pred_pc,
    input  logic                  pred_taken,
    output logic [DATA_BUS_W-1:0] PC,
    output logic [DATA_BUS_W-1:0] Inst,
    output logic                  Inst_Ready,
    output logic                  Inst_Pred,
    input  logic                  received
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [DATA_BUS_W-1:0] r_fetch_pc;
    logic [DATA_BUS_W-1:0] w_fetch_pc_next;
    logic                  r_mem_req;
    logic                  w_mem_req_next;
    logic [DATA_BUS_W-1:0] r_mem_addr;
    logic [DATA_BUS_W-1:0] w_mem_addr_next;

    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic [ENTRY_W-1:0]    w_head_bits;
    queue_entry_t          w_head;
    queue_entry_t          w_push_entry;

    logic [6:0]            w_opcode;
    logic                  w_is_jal;
    logic                  w_is_taken_br;
    logic                  w_pred;
    logic [DATA_BUS_W-1:0] w_target;
    logic [DATA_BUS_W-1:0] w_clr_target;

    // Static prediction for JAL, predictor-driven for conditional branches.
    assign w_opcode      = mem_data[6:0];
    assign w_is_jal      = (w_opcode == OPC_JAL);
    assign w_is_taken_br = (w_opcode == OPC_BRANCH) && pred_taken;
    assign w_pred        = w_is_jal || w_is_taken_br;
    assign w_target      = w_is_jal      ? r_fetch_pc + imm_j(mem_data) :
                           w_is_taken_br ? r_fetch_pc + imm_b(mem_data) :
                                           r_fetch_pc + 32'd4;
    assign w_clr_target  = clr_pc & 32'hFFFF_FFFC;

    assign w_full = (w_count == CNT_W'(QUEUE_DEPTH));
    assign w_pop  = Inst_Ready && received;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (rdy) begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    // A read that completes on the same edge as clr is already gone, so there
    // is nothing left to drop and the FSM returns straight to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!clr && !w_full) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    w_state_next = ST_IDLE;
                end else if (clr) begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_push          = 1'b0;
        if (clr) begin
            w_fetch_pc_next = w_clr_target;
        end
        case (r_state)
            ST_IDLE: begin
                if (!clr && !w_full) begin
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = r_fetch_pc;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    w_mem_req_next = 1'b0;
                    if (!clr) begin
                        w_push          = 1'b1;
                        w_fetch_pc_next = w_target;
                    end
                end
            end
            ST_DROP: begin
                if (mem_done) begin
                    w_mem_req_next = 1'b0;
                end
            end
            default: w_mem_req_next = 1'b0;
        endcase
    end

    assign w_push_entry = '{pc: r_fetch_pc, inst: mem_data, pred: w_pred};

    inst_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_en        (rdy),
        .i_flush     (clr),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head_bits),
        .o_count     (w_count)
    );

    assign w_head     = w_head_bits;
    assign PC         = w_head.pc;
    assign Inst       = w_head.inst;
    assign Inst_Pred  = w_head.pred;
    assign Inst_Ready = (w_count != '0);

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign pred_pc  = r_fetch_pc;

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage sitting directly upstream of the decode/issue stage. Holds the fetch PC, issues one-word reads to the memory controller, pre-decodes JAL and conditional branches to pick the next fetch PC (static for JAL, predictor-driven for branches), and buffers fetched instructions in a circular queue. Decode pops the queue through a valid/received handshake. The flow controller redirects the block with `clr` on misprediction.

## Interface
Parameters:
- QUEUE_DEPTH, 8, instruction queue entries; power of two, ≥2
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; block fully frozen when low
- clr  in  1  flush/redirect from flow controller
- clr_pc  in  32  redirect target; bits [1:0] forced to 0
- mem_req  out  1  word read request
- mem_addr  out  32  read address, word aligned
- mem_done  in  1  one-cycle completion pulse; never asserted while rdy low
- mem_data  in  32  read data, valid with mem_done
- pred_pc  out  32  PC being looked up in predictor (= fetch_pc)
- pred_taken  in  1  combinational predictor answer for pred_pc
- PC  out  32  PC of queue head
- Inst  out  32  instruction at queue head
- Inst_Ready  out  1  queue head valid
- Inst_Pred  out  1  predicted-taken bit of queue head
- received  in  1  decode accepts head this cycle

## Operation
- Queue entry = {pc[31:0], inst[31:0], pred}; head drives PC/Inst/Inst_Pred combinationally; Inst_Ready = (count != 0).
- Pop at clock edge when Inst_Ready && received && rdy. Push on accepted mem_done. Push+pop same edge: count unchanged. Pointers wrap mod QUEUE_DEPTH.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if count < QUEUE_DEPTH and !clr → mem_req<=1, mem_addr<=fetch_pc, → WAIT.
  - WAIT: mem_req held. On mem_done: mem_req<=0, push entry, update fetch_pc, → IDLE.
  - DROP: waits for outstanding read from before a flush; on mem_done discard data, mem_req<=0, → IDLE.
- Next-PC on mem_done (opcode = mem_data[6:0]):
  - 1101111 (JAL): fetch_pc + sext J-imm {inst[31], inst[19:12], inst[20], inst[30:21], 0}; pred=1.
  - 1100011 (branch) and pred_taken: fetch_pc + sext B-imm {inst[31], inst[7], inst[30:25], inst[11:8], 0}; pred=1.
  - otherwise (incl. JALR, untaken branch): fetch_pc + 4; pred=0.
  - Addition is 32-bit, wraps modulo 2^32.
- Only one read is outstanding; issuing requires a free slot, so a push can never overflow.
- clr (sampled at edge, rdy high) has priority over push, pop, and issue: queue emptied (count 0, pointers 0), fetch_pc<=clr_pc&~3; WAIT→DROP, IDLE→IDLE, DROP→DROP (fetch_pc updated again). A mem_done in the same cycle as clr is discarded.
- rdy low: no register changes; outputs hold.

## Timing
- Reset (async): state IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=0, count=0, so Inst_Ready=0. PC/Inst/Inst_Pred read the emptied entry 0, reset to 0.
- mem_req rises the edge after IDLE is entered with space, earliest 1 cycle after reset release.
- mem_done at edge N → entry visible on Inst_Ready after edge N; next mem_req after edge N+1. Throughput is 1 instruction per (memory latency + 2) cycles.
- A pop frees a slot usable by an issue decision on the following edge.
- After clr at edge N: Inst_Ready=0 after N; new fetch at clr_pc requested at N+1 from IDLE, or after the discarded mem_done from DROP.

## Structure
- Shared package/constants: opcode values (JAL, branch), Data_Bus width, instruction-entry width; reuse the codebase constants file.
- Sub-module `inst_queue`: parameterised circular FIFO (push, pop, flush, count, head outputs). The FSM and next-PC logic stay in `inst_fetcher`.

## Test plan
- Reset, memory returns 32'h00000013 (addi) with 2-cycle latency, received=1 → reads at 0,4,8; Inst_Ready pulses carry PC 0,4,8, Inst_Pred=0.
- JAL at PC 0x10, imm +0x20 (mem_data 32'h0200006F) → next mem_addr 0x30, Inst_Pred=1 on that entry.
- Branch at PC 0x40, imm −8 (32'hFE000CE3), pred_taken=1 → next addr 0x38; repeat with pred_taken=0 → 0x44.
- received=0, QUEUE_DEPTH=8 → exactly 8 reads, then mem_req stays 0. One pop → one more read issues.
- clr with clr_pc=0x103 while in WAIT → queue empties, in-flight data discarded, next mem_addr=0x100.
- rdy low for 5 cycles with full queue and received=1 → no pop, outputs stable; pops resume on rdy high.
